// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined rv32i immediate generator behind a valid/ready skid buffer
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   instr, src, tag_in    instruction word, format select, sideband tag
//   in_valid, in_ready    input handshake (in_ready is registered)
//   imm_out, tag_out      extended immediate and its tag
//   imm_err               unsupported format/opcode, imm_out forced to 0
//   out_valid, out_ready  output handshake
module imm_gen_pipe #(
   parameter int XLEN        = 32,
   parameter bit AUTO_DECODE = 1'b0,
   parameter int TAG_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic [2:0]       src,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [XLEN-1:0]  imm_out,
   output logic [TAG_W-1:0] tag_out,
   output logic             imm_err,
   output logic             out_valid,
   input  logic             out_ready
);
   logic [6:0]       opc;
   logic [2:0]       f3, dec, fmt;
   logic             sgn, err_c, in_fire, load_out;
   logic [XLEN-1:0]  imm_c, imm_u, imm_sh;
   logic             skid_valid, skid_err;
   logic [XLEN-1:0]  skid_imm;
   logic [TAG_W-1:0] skid_tag;
   assign opc      = instr[6:0];
   assign f3       = instr[14:12];
   assign sgn      = instr[31];
   assign in_fire  = in_valid & in_ready;
   assign load_out = ~out_valid | out_ready;
   // The shift drops the surplus sign copies, leaving instr[31:12] at bit 12 upward.
   assign imm_u  = {{(XLEN-20){sgn}}, instr[31:12]} << 12;
   assign imm_sh = (XLEN == 64) ? {{(XLEN-6){1'b0}}, instr[25:20]} : {{(XLEN-5){1'b0}}, instr[24:20]};
   always_comb begin
      // funct3 001/101 under OP-IMM are the shifts; CSR immediates have funct3[2] set.
      dec = (opc == 7'b0000011 || opc == 7'b1100111) ? 3'd0 :
            (opc == 7'b0010011) ? ((f3[1:0] == 2'b01) ? 3'd6 : 3'd0) :
            (opc == 7'b0100011) ? 3'd1 :
            (opc == 7'b1100011) ? 3'd2 :
            (opc == 7'b0110111 || opc == 7'b0010111) ? 3'd4 :
            (opc == 7'b1101111) ? 3'd3 :
            (opc == 7'b1110011) ? (f3[2] ? 3'd5 : 3'd0) : 3'd7;
      fmt   = AUTO_DECODE ? dec : src;
      err_c = (fmt == 3'd7);
      imm_c = (fmt == 3'd0) ? {{(XLEN-12){sgn}}, instr[31:20]} :
              (fmt == 3'd1) ? {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]} :
              (fmt == 3'd2) ? {{(XLEN-12){sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
              (fmt == 3'd3) ? {{(XLEN-20){sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
              (fmt == 3'd4) ? imm_u :
              (fmt == 3'd5) ? {{(XLEN-5){1'b0}}, instr[19:15]} :
              (fmt == 3'd6) ? imm_sh : '0;
   end
   // A full skid implies a valid, stalled output register, so in_ready tracks the next skid state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         imm_out    <= '0;
         tag_out    <= '0;
         imm_err    <= 1'b0;
         skid_valid <= 1'b0;
         skid_imm   <= '0;
         skid_tag   <= '0;
         skid_err   <= 1'b0;
      end else begin
         in_ready <= skid_valid ? out_ready : (load_out | ~in_fire);
         if (skid_valid) begin
            if (out_ready) begin
               imm_out    <= skid_imm;
               tag_out    <= skid_tag;
               imm_err    <= skid_err;
               skid_valid <= 1'b0;
            end
         end else if (load_out) begin
            out_valid <= in_fire;
            if (in_fire) begin
               imm_out <= imm_c;
               tag_out <= tag_in;
               imm_err <= err_c;
            end
         end else if (in_fire) begin
            skid_imm   <= imm_c;
            skid_tag   <= tag_in;
            skid_err   <= err_c;
            skid_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table vectors, handshake corner sequences and a random stream scored on three configurations
module tb_imm_gen_pipe;
   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src;
      logic [31:0] e32;
      logic [63:0] e64;
      logic        err;
      logic [31:0] ea;
      logic        erra;
   } vec_t;
   typedef struct {
      logic [31:0] tag;
      logic [31:0] e32;
      logic [63:0] e64;
      logic        err;
      logic [31:0] ea;
      logic        erra;
   } exp_t;
   logic        clk, rst_n, in_valid, out_ready, rnd;
   logic [31:0] instr, tag_in;
   logic [2:0]  src;
   logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, err0, err1, err2;
   logic [31:0] imm0, imm2, tag0, tag1, tag2;
   logic [63:0] imm1;
   int          n_tests, n_fail;
   exp_t        cur;
   exp_t        q0[$], q1[$], q2[$];
   vec_t        v[14];
   logic [6:0]  ops[10];
   imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(32)) u32 (
      .clk(clk), .rst_n(rst_n), .instr(instr), .src(src), .tag_in(tag_in), .in_valid(in_valid),
      .in_ready(rdy0), .imm_out(imm0), .tag_out(tag0), .imm_err(err0), .out_valid(ov0), .out_ready(out_ready));
   imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b0), .TAG_W(32)) u64 (
      .clk(clk), .rst_n(rst_n), .instr(instr), .src(src), .tag_in(tag_in), .in_valid(in_valid),
      .in_ready(rdy1), .imm_out(imm1), .tag_out(tag1), .imm_err(err1), .out_valid(ov1), .out_ready(out_ready));
   imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1), .TAG_W(32)) uau (
      .clk(clk), .rst_n(rst_n), .instr(instr), .src(src), .tag_in(tag_in), .in_valid(in_valid),
      .in_ready(rdy2), .imm_out(imm2), .tag_out(tag2), .imm_err(err2), .out_valid(ov2), .out_ready(out_ready));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   function automatic logic [64:0] ext(input logic [31:0] i, input logic [2:0] f, input bit w64);
      longint sl, t, r;
      sl = longint'($signed(i));
      t  = sl >>> 31;
      case (f)
         3'd0: r = sl >>> 20;
         3'd1: begin t = sl >>> 25; r = (t << 5) | longint'(i[11:7]); end
         3'd2: r = (t << 12) | longint'({i[7], i[30:25], i[11:8], 1'b0});
         3'd3: r = (t << 20) | longint'({i[19:12], i[20], i[30:21], 1'b0});
         3'd4: r = (sl >>> 12) << 12;
         3'd5: r = longint'(i[19:15]);
         3'd6: r = w64 ? longint'(i[25:20]) : longint'(i[24:20]);
         default: r = 0;
      endcase
      return {f == 3'd7, 64'(r)};
   endfunction
   function automatic logic [2:0] dec(input logic [31:0] i);
      case (i[6:0])
         7'b0000011, 7'b1100111: return 3'd0;
         7'b0010011: return (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'd6 : 3'd0;
         7'b0100011: return 3'd1;
         7'b1100011: return 3'd2;
         7'b0110111, 7'b0010111: return 3'd4;
         7'b1101111: return 3'd3;
         7'b1110011: return i[14] ? 3'd5 : 3'd0;
         default: return 3'd7;
      endcase
   endfunction
   function automatic exp_t model(input logic [31:0] i, input logic [2:0] s, input logic [31:0] t);
      exp_t e;
      logic [64:0] r;
      e.tag = t;
      r = ext(i, s, 1'b0);
      e.e32 = r[31:0];
      e.err = r[64];
      r = ext(i, s, 1'b1);
      e.e64 = r[63:0];
      r = ext(i, dec(i), 1'b0);
      e.ea = r[31:0];
      e.erra = r[64];
      return e;
   endfunction
   function automatic exp_t mk(input vec_t x, input logic [31:0] t);
      exp_t e;
      e.tag = t; e.e32 = x.e32; e.e64 = x.e64; e.err = x.err; e.ea = x.ea; e.erra = x.erra;
      return e;
   endfunction
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         q0.delete(); q1.delete(); q2.delete();
      end else begin
         if (ov0 && out_ready) begin
            if (q0.size() == 0) chk("u32 unexpected output", {63'd0, ov0}, 64'd0);
            else begin
               e = q0.pop_front();
               chk("u32 imm", imm0, e.e32); chk("u32 tag", tag0, e.tag); chk("u32 err", err0, e.err);
            end
         end
         if (ov1 && out_ready) begin
            if (q1.size() == 0) chk("u64 unexpected output", {63'd0, ov1}, 64'd0);
            else begin
               e = q1.pop_front();
               chk("u64 imm", imm1, e.e64); chk("u64 tag", tag1, e.tag); chk("u64 err", err1, e.err);
            end
         end
         if (ov2 && out_ready) begin
            if (q2.size() == 0) chk("auto unexpected output", {63'd0, ov2}, 64'd0);
            else begin
               e = q2.pop_front();
               chk("auto imm", imm2, e.ea); chk("auto tag", tag2, e.tag); chk("auto err", err2, e.erra);
            end
         end
         if (in_valid && rdy0) q0.push_back(cur);
         if (in_valid && rdy1) q1.push_back(cur);
         if (in_valid && rdy2) q2.push_back(cur);
      end
   end
   task automatic set_in(input exp_t e, input logic [31:0] i, input logic [2:0] s);
      instr = i; src = s; tag_in = e.tag; cur = e; in_valid = 1'b1;
   endtask
   task automatic send(input exp_t e, input logic [31:0] i, input logic [2:0] s);
      int n;
      n = 0;
      set_in(e, i, s);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      while (!rdy0 && n < 40) begin
         @(posedge clk); #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      chk("in_ready accept", {63'd0, rdy0}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask
   initial begin
      n_tests = 0; n_fail = 0; rnd = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; src = '0; tag_in = '0;
      cur = model(32'd0, 3'd0, 32'd0);
      v[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
      v[1]  = '{32'h00112623, 3'd1, 32'h0000000C, 64'h000000000000000C, 1'b0, 32'h0000000C, 1'b0};
      v[2]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0};
      v[3]  = '{32'h12345037, 3'd4, 32'h12345000, 64'h0000000012345000, 1'b0, 32'h12345000, 1'b0};
      v[4]  = '{32'h0000007F, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1, 32'h00000000, 1'b1};
      v[5]  = '{32'h03F01093, 3'd6, 32'h0000001F, 64'h000000000000003F, 1'b0, 32'h0000001F, 1'b0};
      v[6]  = '{32'hFFDFF0EF, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0};
      v[7]  = '{32'h340AD073, 3'd5, 32'h00000015, 64'h0000000000000015, 1'b0, 32'h00000015, 1'b0};
      v[8]  = '{32'h34011073, 3'd5, 32'h00000002, 64'h0000000000000002, 1'b0, 32'h00000340, 1'b0};
      v[9]  = '{32'hFF812283, 3'd0, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, 32'hFFFFFFF8, 1'b0};
      v[10] = '{32'h80000017, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 32'h80000000, 1'b0};
      v[11] = '{32'h4050D093, 3'd0, 32'h00000405, 64'h0000000000000405, 1'b0, 32'h00000005, 1'b0};
      v[12] = '{32'h000080E7, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1, 32'h00000000, 1'b0};
      v[13] = '{32'h00000033, 3'd1, 32'h00000000, 64'h0000000000000000, 1'b0, 32'h00000000, 1'b1};
      ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h00};
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset out_valid", {63'd0, ov0}, 64'd0);
      chk("reset in_ready", {63'd0, rdy0}, 64'd0);
      chk("reset imm", imm0, 64'd0);
      chk("reset tag", tag0, 64'd0);
      chk("reset err", {63'd0, err0}, 64'd0);
      chk("reset u64 imm", imm1, 64'd0);
      @(negedge clk);
      chk("in_ready after reset", {63'd0, rdy0}, 64'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         send(mk(v[i], 32'(100 + i)), v[i].instr, v[i].src);
         if (i == 0) begin
            @(negedge clk);
            chk("latency out_valid", {63'd0, ov0}, 64'd1);
            @(posedge clk); #1;
         end
      end
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b0;
      send(mk(v[1], 32'd1), v[1].instr, v[1].src);
      send(mk(v[2], 32'd2), v[2].instr, v[2].src);
      set_in(mk(v[3], 32'd3), v[3].instr, v[3].src);
      @(negedge clk);
      chk("stall in_ready low", {63'd0, rdy0}, 64'd0);
      chk("stall tag held", tag0, 64'd1);
      chk("stall out_valid", {63'd0, ov0}, 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall imm held", imm0, 64'h0C);
      chk("stall tag still held", tag0, 64'd1);
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("drain cycle in_ready", {63'd0, rdy0}, 64'd0);
      @(negedge clk);
      chk("skid moved in_ready", {63'd0, rdy0}, 64'd1);
      chk("skid moved tag", tag0, 64'd2);
      @(posedge clk); #1;
      send(mk(v[6], 32'd4), v[6].instr, v[6].src);
      repeat (3) @(posedge clk);
      #1 chk("stream drained", 64'(q0.size()), 64'd0);
      out_ready = 1'b0;
      send(mk(v[9], 32'd5), v[9].instr, v[9].src);
      send(mk(v[10], 32'd6), v[10].instr, v[10].src);
      rst_n = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mid reset out_valid", {63'd0, ov0}, 64'd0);
      chk("mid reset in_ready", {63'd0, rdy0}, 64'd0);
      chk("mid reset imm", imm0, 64'd0);
      chk("mid reset tag", tag0, 64'd0);
      chk("mid reset u64 out_valid", {63'd0, ov1}, 64'd0);
      @(negedge clk);
      chk("post reset in_ready", {63'd0, rdy0}, 64'd1);
      chk("post reset no output", {63'd0, ov0}, 64'd0);
      @(posedge clk); #1;
      rnd = 1'b1;
      for (int k = 0; k < 300; k++) begin
         logic [31:0] ri;
         logic [2:0]  rs;
         ri = $urandom;
         ri[6:0] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
         rs = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         send(model(ri, rs, 32'(1000 + k)), ri, rs);
      end
      rnd = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("final u32 queue empty", 64'(q0.size()), 64'd0);
      chk("final u64 queue empty", 64'(q1.size()), 64'd0);
      chk("final auto queue empty", 64'(q2.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
